// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Iterative restoring divider producing quotient (LO) and
//               remainder (HI) for signed and unsigned operands, one
//               shift-subtract step per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int c_CW = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dvd_raw;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_borrow;
    logic [WIDTH-1:0] w_trial;
    logic             w_last;

    assign w_dvd_neg = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

    // The shifted partial remainder is 33 bits wide; when it is not below the
    // divisor the difference always fits back into WIDTH bits.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_borrow = (w_shift < {1'b0, r_dvs});
    assign w_trial  = w_shift[WIDTH-1:0] - r_dvs;
    assign w_last   = (r_count == c_CW'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next = (divisor == '0) ? c_FIX : c_RUN;
                end
            end
            c_RUN: begin
                if (w_last) begin
                    w_next = c_FIX;
                end
            end
            c_FIX:   w_next = c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_count       <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_dvd_raw     <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_dz          <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_count   <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_dvd_mag;
                        r_dvs     <= w_dvs_mag;
                        r_dvd_raw <= dividend;
                        r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r   <= w_dvd_neg;
                        r_dz      <= (divisor == '0);
                    end
                end
                c_RUN: begin
                    r_count <= r_count + 1'b1;
                    if (w_borrow) begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end else begin
                        r_rem <= w_trial;
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end
                end
                c_FIX: begin
                    // Divide-by-zero returns all-ones and the untouched dividend.
                    if (r_dz) begin
                        r_quotient    <= '1;
                        r_remainder   <= r_dvd_raw;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_quotient    <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
                        r_remainder   <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == c_RUN) || (r_state == c_FIX);
    assign done        = (r_state == c_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed and randomised checks of seq_divider against a
//               magnitude-based reference held in a result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] am;
        logic [31:0] bm;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            am   = (s && a[31]) ? (32'd0 - a) : a;
            bm   = (s && b[31]) ? (32'd0 - b) : b;
            e.q  = am / bm;
            e.r  = am % bm;
            if (s && (a[31] ^ b[31])) e.q = 32'd0 - e.q;
            if (s && a[31])           e.r = 32'd0 - e.r;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Entered and left at #1 after a rising edge.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input exp_t e, input bit poke);
        exp_t got;
        int   k;
        int   lat;
        lat = (b == 32'd0) ? 1 : 33;
        sb.push_back(e);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
        check({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
        k = 0;
        while (!done && k < 60) begin
            if (poke && k == 5) begin
                start    = 1'b1;
                dividend = 32'd12345;
                divisor  = 32'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            k++;
        end
        got = sb.pop_front();
        if (!done) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s timeout: observed no done after %0d cycles, expected done", tag, k);
            return;
        end
        check({tag, " latency"}, k, lat);
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, " quotient"}, quotient, got.q);
        check({tag, " remainder"}, remainder, got.r);
        check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, got.dz});
        if (poke) begin
            start     = 1'b1;
            dividend  = 32'd77;
            divisor   = 32'd5;
            is_signed = 1'b0;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
        if (poke) begin
            check({tag, " start_in_done_ignored"}, {31'd0, busy}, 32'd0);
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                check({tag, " hold_busy"}, {31'd0, busy}, 32'd0);
                check({tag, " hold_q"}, quotient, got.q);
                check({tag, " hold_r"}, remainder, got.r);
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst quotient", quotient, 32'd0);
        check("rst remainder", remainder, 32'd0);
        check("rst dz", {31'd0, div_by_zero}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("idle busy", {31'd0, busy}, 32'd0);
        check("idle done", {31'd0, done}, 32'd0);
        check("idle quotient", quotient, 32'd0);
        check("idle remainder", remainder, 32'd0);

        run_op("divu 100/7", 1'b0, 32'd100, 32'd7, '{32'd14, 32'd2, 1'b0}, 1'b0);
        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}, 1'b0);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, '{32'hFFFF_FFFD, 32'd1, 1'b0}, 1'b0);
        run_op("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h8000_0000, 32'd0, 1'b0}, 1'b0);
        run_op("divu big/1", 1'b0, 32'hFFFF_FFFF, 32'd1, '{32'hFFFF_FFFF, 32'd0, 1'b0}, 1'b0);
        run_op("divu 3/10", 1'b0, 32'd3, 32'd10, '{32'd0, 32'd3, 1'b0}, 1'b0);
        run_op("divu 5/0", 1'b0, 32'd5, 32'd0, '{32'hFFFF_FFFF, 32'd5, 1'b1}, 1'b0);
        run_op("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1}, 1'b0);

        // Abort a running divide with reset
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        check("abort dz", {31'd0, div_by_zero}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort idle busy", {31'd0, busy}, 32'd0);

        run_op("divu 9/4", 1'b0, 32'd9, 32'd4, '{32'd2, 32'd1, 1'b0}, 1'b0);
        run_op("poke 100/7", 1'b0, 32'd100, 32'd7, '{32'd14, 32'd2, 1'b0}, 1'b1);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            rs = 1'($urandom);
            run_op("random", rs, ra, rb, model(rs, ra, rb), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
